// File: rtl/downcounter_4bit_pkg.sv
// Shared width and count type for the 4-bit down-counter.
package downcounter_4bit_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/downcounter_4bit_jk.sv
// JK flip-flop with async clear (wins) and async active-low preset.
module jk_flip_flop (
    input  logic clk,
    input  logic clr,
    input  logic pre_bar,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic set;

    // Preset is masked by clear, so dropping clear with preset held sets q.
    assign set = ~(pre_bar | clr);

    always_ff @(posedge clk or posedge clr or posedge set) begin
        if (clr) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/downcounter_4bit.sv
// Synchronous 4-bit down-counter from four toggle-mode JK flip-flops.
module downcounter_4bit
    import downcounter_4bit_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic pre_bar,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q0_bar,
    output logic Q1_bar,
    output logic Q2_bar,
    output logic Q3_bar
);

    cnt_t q;
    cnt_t q_bar;
    cnt_t t;

    // A stage toggles when every lower stage is zero (borrow chain).
    assign t[0] = 1'b1;
    assign t[1] = q_bar[0];
    assign t[2] = t[1] & q_bar[1];
    assign t[3] = t[2] & q_bar[2];

    for (genvar i = 0; i < CNT_W; i++) begin : g_stage
        jk_flip_flop u_ff (
            .clk     (clk),
            .clr     (clr),
            .pre_bar (pre_bar),
            .j       (t[i]),
            .k       (t[i]),
            .q       (q[i]),
            .q_bar   (q_bar[i])
        );
    end

    assign Q0     = q[0];
    assign Q1     = q[1];
    assign Q2     = q[2];
    assign Q3     = q[3];
    assign Q0_bar = q_bar[0];
    assign Q1_bar = q_bar[1];
    assign Q2_bar = q_bar[2];
    assign Q3_bar = q_bar[3];

endmodule

// File: tb/tb_downcounter_4bit.sv
// Bench for downcounter_4bit: counting model plus directed async cases.
`timescale 1ns/100ps
module tb_downcounter_4bit;

    logic clk;
    logic clr;
    logic pre_bar;
    logic Q0, Q1, Q2, Q3;
    logic Q0_bar, Q1_bar, Q2_bar, Q3_bar;

    int checks = 0;
    int errors = 0;

    int   m = 0;
    logic valid = 1'b0;

    logic [3:0] q;
    logic [3:0] qb;
    assign q  = {Q3, Q2, Q1, Q0};
    assign qb = {Q3_bar, Q2_bar, Q1_bar, Q0_bar};

    downcounter_4bit dut (
        .clk     (clk),
        .clr     (clr),
        .pre_bar (pre_bar),
        .Q0      (Q0),
        .Q1      (Q1),
        .Q2      (Q2),
        .Q3      (Q3),
        .Q0_bar  (Q0_bar),
        .Q1_bar  (Q1_bar),
        .Q2_bar  (Q2_bar),
        .Q3_bar  (Q3_bar)
    );

    initial begin
        clk = 1'b0;
        forever #3 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference: count down modulo 16 unless clear or preset is held.
    always @(posedge clk) begin
        if (!clr && pre_bar)
            m = (m + 15) % 16;
    end

    always @(clr or pre_bar) begin
        if (clr) begin
            m = 0;
            valid = 1'b1;
        end else if (!pre_bar) begin
            m = 15;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_q", q, 4'(m));
            check("model_bar", qb, ~4'(m));
        end
    end

    initial begin
        clr = 1'b0;
        pre_bar = 1'b1;

        #20 clr = 1'b1;
        #1 check("clr_q", q, 4'h0);
        check("clr_bar", qb, 4'hF);
        #9 clr = 1'b0;
        #4 check("after_clr_1", q, 4'hF);
        #6 check("after_clr_2", q, 4'hE);
        #6 check("after_clr_3", q, 4'hD);

        #24 pre_bar = 1'b0;
        #1 check("pre_q", q, 4'hF);
        check("pre_bar_out", qb, 4'h0);
        #5 check("pre_hold", q, 4'hF);
        #4 pre_bar = 1'b1;
        #2 check("after_pre_1", q, 4'hE);
        #6 check("after_pre_2", q, 4'hD);

        #4 clr = 1'b1;
        #2 clr = 1'b0;
        repeat (16) @(posedge clk);
        #1 check("wrap_zero", q, 4'h0);
        @(posedge clk);
        #1 check("wrap_f", q, 4'hF);

        #0.5;
        clr = 1'b1;
        pre_bar = 1'b0;
        #1 check("both_q", q, 4'h0);
        check("both_bar", qb, 4'hF);
        #1 clr = 1'b0;
        #1 check("clr_drop_pre", q, 4'hF);
        @(posedge clk);
        #1 check("pre_held_edge", q, 4'hF);
        pre_bar = 1'b1;

        repeat (5) @(posedge clk);
        #1 check("at_a", q, 4'hA);
        #1 clr = 1'b1;
        #0.5 check("clr_mid", q, 4'h0);
        @(posedge clk);
        #1 check("clr_edge_ignored", q, 4'h0);
        clr = 1'b0;
        #1 check("clr_hold", q, 4'h0);
        @(posedge clk);
        #1 check("clr_resume", q, 4'hF);
        @(posedge clk);
        #1 check("clr_resume_2", q, 4'hE);

        #10;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
